perf_counter_unit: RTL
======================

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 The block SHALL have parameter NUM_EVT, default 4, meaning the number of event channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the width of each event counter and of the cycle counter.
REQ-003 The block SHALL have parameter SATURATE, default 1, selecting overflow mode: 1 = stick at max, 0 = wrap to 0.
REQ-004 clk_i  input  1  the one clock; all state changes on the rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-low.
REQ-006 start_i  input  1  run enable; counting proceeds while high.
REQ-007 clear_i  input  1  synchronous clear of the live counters, overflow flags and done state.
REQ-008 limit_i  input  CNT_W  cycle limit; 0 means unlimited.
REQ-009 evt_i  input  NUM_EVT  per-channel event strobes (e.g. stall, flush), one count per high cycle.
REQ-010 snap_req_i  input  1  snapshot request pulse.
REQ-011 snap_ack_i  input  1  consumer acknowledges the snapshot.
REQ-012 snap_valid_o  output  1  shadow registers hold an unacknowledged snapshot.
REQ-013 rd_sel_i  input  5  shadow read select: 0..NUM_EVT-1 = event k, NUM_EVT = cycle count.
REQ-014 rd_data_o  output  CNT_W  combinational read of the selected shadow register; 0 for out-of-range select.
REQ-015 ovf_o  output  NUM_EVT+1  sticky overflow flags (bit NUM_EVT = cycle counter).
REQ-016 done_o  output  1  high while in DONE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE with start_i=1, the FSM SHALL enter RUN on the next edge; no counting occurs in that cycle.
REQ-019 In RUN, each edge SHALL increment the cycle counter by 1 and each counter k by 1 when evt_i[k]=1.
REQ-020 In RUN with start_i=0, the FSM SHALL return to IDLE and hold all counters (pause, no loss).
REQ-021 In RUN, when limit_i≠0 and the cycle counter becomes equal to limit_i on this edge, the FSM SHALL enter DONE; the events of that final cycle are counted.
REQ-022 In DONE, all counters SHALL be frozen regardless of start_i and evt_i.
REQ-023 clear_i=1 in any state SHALL, on the next edge, zero all live counters and ovf_o and force IDLE; clear_i has priority over start_i and limit detection.
REQ-024 When a counter at all-ones is incremented, it SHALL hold all-ones if SATURATE=1, or become 0 if SATURATE=0; in both modes it SHALL set its ovf_o bit, which stays set until clear or reset.
REQ-025 When snap_valid_o=0 and snap_req_i=1, the shadow registers SHALL capture the live counter values present before that edge's update (pre-increment, pre-clear), and snap_valid_o SHALL rise on that edge.
REQ-026 snap_req_i while snap_valid_o=1 SHALL be ignored; the shadow registers SHALL not change.
REQ-027 snap_ack_i while snap_valid_o=1 SHALL drop snap_valid_o on the next edge; when snap_ack_i and snap_req_i are both high in the same cycle, the ack is taken and the request ignored.
REQ-028 Snapshot operation SHALL be independent of FSM state, including IDLE and DONE.
REQ-029 A change of limit_i during RUN SHALL take effect immediately; if the cycle counter already exceeds the new limit, DONE is entered only on wrap-around equality (SATURATE=0) and never otherwise.

Reset
REQ-030 On rst_i=0, asynchronously: FSM = IDLE, all live and shadow counters = 0, ovf_o = 0, snap_valid_o = 0, done_o = 0.
REQ-031 Reset SHALL abort any run or pending snapshot without output glitch beyond the asynchronous clear; release is taken synchronously on the first edge with rst_i=1.

Structure
REQ-032 State encoding (IDLE/RUN/DONE) and the rd_sel_i width constant SHALL live in the shared CPU package.
REQ-033 One sub-module, perf_sat_counter (CNT_W, SATURATE; inc, clr, value, ovf), SHALL be instantiated NUM_EVT+1 times.
REQ-034 No combinational path SHALL exist from evt_i to any output.

Verification
REQ-035 Directed scenario: limit_i=64, start_i=1 held, evt_i[0] high every 4th cycle -> done_o rises after exactly 64 counting cycles; snapshot gives cycles=64, evt0=16.
REQ-036 Directed scenario: start_i dropped for 10 cycles mid-run -> counts resume from held values; done_o is delayed by exactly 10 cycles.
REQ-037 Directed scenario: CNT_W=4 with SATURATE=1 and SATURATE=0, evt_i[1] high for 20 cycles -> counter reads 15 (sat) or 4 (wrap); ovf_o[1]=1 in both.
REQ-038 Directed scenario: snap_req_i and clear_i in the same cycle with evt0=7 -> shadow evt0=7, live evt0=0, snap_valid_o=1; a second req before ack leaves shadow unchanged.
REQ-039 Directed scenario: rst_i asserted mid-RUN between edges -> all outputs are 0 immediately; rd_sel_i=31 returns 0.

Source files
------------

// File: rtl/perf_counter_unit_pkg.sv
// Shared definitions for the performance counter unit: FSM state encoding
// and the width of the shadow read-select bus.
package perf_counter_unit_pkg;

    // Run-control states of the counter unit
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pcu_state_t;

    // Read select covers up to 16 event channels plus the cycle counter
    localparam int RD_SEL_W = 5;

endpackage

// File: rtl/perf_counter_unit_sat.sv
// perf_sat_counter: one live counter with synchronous clear, selectable
// saturate/wrap behaviour at all-ones, and a sticky overflow flag.
module perf_sat_counter #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    // Count on inc; clear wins over increment; overflow is sticky until clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (&value) begin
                ovf   <= 1'b1;
                value <= (SATURATE != 0) ? value : '0;
            end else begin
                value <= value + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: NUM_EVT event counters plus a cycle counter under an
// IDLE/RUN/DONE run controller, with a snapshot/ack shadow register bank
// that the consumer reads through rd_sel_i.
module perf_counter_unit
    import perf_counter_unit_pkg::*;
#(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                clear_i,
    input  logic [CNT_W-1:0]    limit_i,
    input  logic [NUM_EVT-1:0]  evt_i,
    input  logic                snap_req_i,
    input  logic                snap_ack_i,
    output logic                snap_valid_o,
    input  logic [RD_SEL_W-1:0] rd_sel_i,
    output logic [CNT_W-1:0]    rd_data_o,
    output logic [NUM_EVT:0]    ovf_o,
    output logic                done_o
);

    pcu_state_t       state_reg;
    logic             done_reg;
    logic             run_active;
    logic             limit_hit;
    logic [CNT_W-1:0] cyc_now;
    logic [CNT_W-1:0] cyc_next;
    logic             snap_valid_reg;

    // Index NUM_EVT holds the cycle counter, lower indices the event counters
    logic [CNT_W-1:0] live_value [NUM_EVT+1];
    logic [CNT_W-1:0] shadow_reg [NUM_EVT+1];

    assign run_active = (state_reg == ST_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVT; gi++) begin : g_evt
            perf_sat_counter #(
                .CNT_W    (CNT_W),
                .SATURATE (SATURATE)
            ) u_evt_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .inc   (run_active && evt_i[gi]),
                .clr   (clear_i),
                .value (live_value[gi]),
                .ovf   (ovf_o[gi])
            );
        end
    endgenerate

    perf_sat_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
    ) u_cyc_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (run_active),
        .clr   (clear_i),
        .value (live_value[NUM_EVT]),
        .ovf   (ovf_o[NUM_EVT])
    );

    // Predict the cycle count after this edge; a counter stuck at the limit
    // (saturated) does not count as "becoming" equal again
    always_comb begin
        cyc_now = live_value[NUM_EVT];
        if (&cyc_now) begin
            cyc_next = (SATURATE != 0) ? cyc_now : '0;
        end else begin
            cyc_next = cyc_now + CNT_W'(1);
        end
        limit_hit = (limit_i != '0) && (cyc_next == limit_i) && (cyc_now != limit_i);
    end

    // Run controller; clear overrides start and limit, DONE only left by clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end else if (clear_i) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (limit_hit) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else if (!start_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Snapshot handshake: capture pre-update live values when empty, ack frees
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            snap_valid_reg <= 1'b0;
            for (int i = 0; i <= NUM_EVT; i++) shadow_reg[i] <= '0;
        end else if (snap_valid_reg) begin
            if (snap_ack_i) snap_valid_reg <= 1'b0;
        end else if (snap_req_i) begin
            snap_valid_reg <= 1'b1;
            for (int i = 0; i <= NUM_EVT; i++) shadow_reg[i] <= live_value[i];
        end
    end

    // Shadow read mux; selects beyond the cycle counter return zero
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i <= NUM_EVT; i++) begin
            if (rd_sel_i == RD_SEL_W'(i)) rd_data_o = shadow_reg[i];
        end
    end

    assign snap_valid_o = snap_valid_reg;
    assign done_o       = done_reg;

endmodule
